// File: rtl/rf_issue_scoreboard.sv
// Register-read issue scoreboard: tracks pending register writes with a remaining-latency
// counter per register and stalls the ID->REG pair while any source is not yet forwardable.
module rf_issue_scoreboard #(
    parameter int LAT_W    = 3,
    parameter int STALL_CW = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic                ex_allowin,
    input  logic [4:0]          src_rj0,
    input  logic [4:0]          src_rk0,
    input  logic [4:0]          src_rj1,
    input  logic [4:0]          src_rk1,
    input  logic [4:0]          dst_rd0,
    input  logic [4:0]          dst_rd1,
    input  logic                dst_we0,
    input  logic                dst_we1,
    input  logic [LAT_W-1:0]    dst_lat0,
    input  logic [LAT_W-1:0]    dst_lat1,
    input  logic                wb_we0,
    input  logic                wb_we1,
    input  logic [4:0]          wb_rd0,
    input  logic [4:0]          wb_rd1,
    output logic                issue_stall,
    output logic                issue_fire,
    output logic [31:0]         busy_mask,
    output logic                pair_conflict,
    output logic [STALL_CW-1:0] stall_cycles
);

    logic [31:0]         busy_q, busy_d;
    logic [LAT_W-1:0]    cnt_q [32];
    logic [LAT_W-1:0]    cnt_d [32];
    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

    // A busy source with zero remaining latency is already on the forwarding net.
    function automatic logic src_ready(input logic [4:0] src);
        return (src == 5'd0) || !busy_q[src] || (cnt_q[src] == '0);
    endfunction

    always_comb begin
        issue_stall   = issue_valid && !(src_ready(src_rj0) && src_ready(src_rk0) &&
                                         src_ready(src_rj1) && src_ready(src_rk1));
        issue_fire    = issue_valid && ex_allowin && !issue_stall;
        pair_conflict = dst_we0 && (dst_rd0 != 5'd0) &&
                        ((src_rj1 == dst_rd0) || (src_rk1 == dst_rd0));
        busy_mask     = busy_q;
        stall_cycles  = stall_cnt_q;
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ex_allowin && busy_q[i] && (cnt_q[i] != '0))
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
        end
        if (wb_we0 && (wb_rd0 != 5'd0)) busy_d[wb_rd0] = 1'b0;
        if (wb_we1 && (wb_rd1 != 5'd0)) busy_d[wb_rd1] = 1'b0;
        // Issue is applied after writeback so a same-cycle set wins; slot1 overrides slot0.
        if (issue_fire) begin
            if (dst_we0 && (dst_rd0 != 5'd0)) begin
                busy_d[dst_rd0] = 1'b1;
                cnt_d[dst_rd0]  = dst_lat0;
            end
            if (dst_we1 && (dst_rd1 != 5'd0)) begin
                busy_d[dst_rd1] = 1'b1;
                cnt_d[dst_rd1]  = dst_lat1;
            end
        end
        if (flush) begin
            busy_d = '0;
            for (int i = 0; i < 32; i++) cnt_d[i] = '0;
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && issue_stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + STALL_CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_rf_issue_scoreboard.sv
// Self-checking bench for rf_issue_scoreboard: directed scenarios followed by random traffic,
// all compared against a per-register pending-write model.
module tb_rf_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush, issue_valid, ex_allowin;
    logic [4:0]  src_rj0, src_rk0, src_rj1, src_rk1, dst_rd0, dst_rd1, wb_rd0, wb_rd1;
    logic        dst_we0, dst_we1, wb_we0, wb_we1;
    logic [2:0]  dst_lat0, dst_lat1;
    logic        issue_stall, issue_fire, pair_conflict;
    logic [31:0] busy_mask, stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which registers wait on a write, and how many advancing cycles until forwardable.
    bit      m_pend [32];
    int      m_left [32];
    longint  m_stalls;

    always #5 clk = ~clk;

    rf_issue_scoreboard #(.LAT_W(3), .STALL_CW(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
        .ex_allowin(ex_allowin), .src_rj0(src_rj0), .src_rk0(src_rk0), .src_rj1(src_rj1),
        .src_rk1(src_rk1), .dst_rd0(dst_rd0), .dst_rd1(dst_rd1), .dst_we0(dst_we0),
        .dst_we1(dst_we1), .dst_lat0(dst_lat0), .dst_lat1(dst_lat1), .wb_we0(wb_we0),
        .wb_we1(wb_we1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .issue_stall(issue_stall),
        .issue_fire(issue_fire), .busy_mask(busy_mask), .pair_conflict(pair_conflict),
        .stall_cycles(stall_cycles)
    );

    function automatic bit can_read(input logic [4:0] r);
        return (r == 5'd0) || !m_pend[r] || (m_left[r] == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; flush = 0; issue_valid = 0; ex_allowin = 1;
        src_rj0 = 0; src_rk0 = 0; src_rj1 = 0; src_rk1 = 0;
        dst_rd0 = 0; dst_rd1 = 0; dst_we0 = 0; dst_we1 = 0; dst_lat0 = 0; dst_lat1 = 0;
        wb_we0 = 0; wb_we1 = 0; wb_rd0 = 0; wb_rd1 = 0;
    endtask

    // One clock: check combinational outputs and visible state, then advance the model.
    task automatic step(input bit do_chk);
        bit          e_stall, e_fire, e_pc;
        logic [31:0] e_mask;
        bit          nx_pend [32];
        int          nx_left [32];
        #1;
        e_stall = issue_valid && !(can_read(src_rj0) && can_read(src_rk0) &&
                                   can_read(src_rj1) && can_read(src_rk1));
        e_fire  = issue_valid && ex_allowin && !e_stall;
        e_pc    = dst_we0 && (dst_rd0 != 0) && (src_rj1 == dst_rd0 || src_rk1 == dst_rd0);
        for (int i = 0; i < 32; i++) e_mask[i] = m_pend[i];
        if (do_chk) begin
            chk("issue_stall", issue_stall, e_stall);
            chk("issue_fire", issue_fire, e_fire);
            chk("pair_conflict", pair_conflict, e_pc);
            chk("busy_mask", busy_mask, e_mask);
            chk("stall_cycles", stall_cycles, m_stalls);
        end
        if (reset) begin
            foreach (m_pend[i]) begin m_pend[i] = 0; m_left[i] = 0; end
            m_stalls = 0;
        end else begin
            if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            for (int i = 0; i < 32; i++) begin
                nx_pend[i] = m_pend[i];
                nx_left[i] = (ex_allowin && m_pend[i] && m_left[i] > 0) ? m_left[i] - 1 : m_left[i];
            end
            if (wb_we0) nx_pend[wb_rd0] = 0;
            if (wb_we1) nx_pend[wb_rd1] = 0;
            if (e_fire && dst_we0) begin nx_pend[dst_rd0] = 1; nx_left[dst_rd0] = dst_lat0; end
            if (e_fire && dst_we1) begin nx_pend[dst_rd1] = 1; nx_left[dst_rd1] = dst_lat1; end
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = (flush || i == 0) ? 0 : nx_pend[i];
                m_left[i] = (flush || i == 0) ? 0 : nx_left[i];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        foreach (m_pend[i]) begin m_pend[i] = 0; m_left[i] = 0; end
        m_stalls = 0;
        reset = 1;
        @(negedge clk);
        step(0);
        reset = 0;

        // 1: make regs busy, then hold reset two cycles
        issue_valid = 1; dst_we0 = 1; dst_rd0 = 5; dst_lat0 = 2; dst_we1 = 1; dst_rd1 = 12; dst_lat1 = 4;
        step(1);
        idle(); issue_valid = 1; src_rj0 = 12;
        step(1);
        idle(); reset = 1; step(1); step(1);
        idle();
        #1;
        chk("t1_busy_mask", busy_mask, 32'h0);
        chk("t1_stall_cycles", stall_cycles, 32'h0);
        chk("t1_issue_stall", issue_stall, 1'b0);
        step(1);

        // 2: load r5 lat 2, dependent pair stalls two cycles then fires
        issue_valid = 1; dst_we0 = 1; dst_rd0 = 5; dst_lat0 = 2;
        step(1);
        idle(); issue_valid = 1; src_rj0 = 5;
        #1; chk("t2_stall_a", issue_stall, 1'b1);
        step(1); step(1);
        #1; chk("t2_fire", issue_fire, 1'b1);
        step(1);
        idle(); wb_we0 = 1; wb_rd0 = 5; step(1);

        // 3: load r7 lat 2, pipeline frozen four cycles, then two advancing cycles
        idle(); issue_valid = 1; dst_we1 = 1; dst_rd1 = 7; dst_lat1 = 2;
        step(1);
        idle(); issue_valid = 1; src_rk1 = 7; ex_allowin = 0;
        for (int k = 0; k < 4; k++) step(1);
        ex_allowin = 1;
        step(1);
        #1; chk("t3_stall_last", issue_stall, 1'b1);
        step(1);
        #1; chk("t3_ready", issue_stall, 1'b0);
        step(1);

        // 4: issue r9 lat 3 with a same-cycle writeback of r9
        idle(); issue_valid = 1; dst_we0 = 1; dst_rd0 = 9; dst_lat0 = 3; wb_we0 = 1; wb_rd0 = 9;
        step(1);
        idle(); #1; chk("t4_busy9", busy_mask[9], 1'b1);
        issue_valid = 1; src_rk0 = 9;
        for (int k = 0; k < 4; k++) step(1);

        // 5: busy r3/r4, then flush while firing r6
        idle(); issue_valid = 1; dst_we0 = 1; dst_rd0 = 3; dst_lat0 = 5; dst_we1 = 1; dst_rd1 = 4; dst_lat1 = 5;
        step(1);
        idle(); issue_valid = 1; flush = 1; dst_we0 = 1; dst_rd0 = 6; dst_lat0 = 3;
        step(1);
        idle(); issue_valid = 1; src_rj0 = 3; src_rk1 = 4;
        #1;
        chk("t5_busy_mask", busy_mask, 32'h0);
        chk("t5_no_stall", issue_stall, 1'b0);
        step(1);

        // 6: r0 traffic and intra-pair dependence
        idle(); issue_valid = 1; dst_we0 = 1; dst_rd0 = 0; dst_lat0 = 7; wb_we1 = 1; wb_rd1 = 0;
        step(1);
        idle(); issue_valid = 1; dst_we0 = 1; dst_rd0 = 8; dst_lat0 = 3; src_rj1 = 8;
        #1;
        chk("t6_busy0", busy_mask[0], 1'b0);
        chk("t6_conflict", pair_conflict, 1'b1);
        chk("t6_no_stall", issue_stall, 1'b0);
        step(1);

        // Random traffic over a small register window to force hazards
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 29) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            ex_allowin  = ($urandom_range(0, 9) < 7);
            src_rj0 = 5'($urandom_range(0, 7)); src_rk0 = 5'($urandom_range(0, 7));
            src_rj1 = 5'($urandom_range(0, 7)); src_rk1 = 5'($urandom_range(0, 7));
            dst_rd0 = 5'($urandom_range(0, 7)); dst_rd1 = 5'($urandom_range(0, 7));
            dst_we0 = 1'($urandom_range(0, 1)); dst_we1 = 1'($urandom_range(0, 1));
            dst_lat0 = 3'($urandom_range(0, 7)); dst_lat1 = 3'($urandom_range(0, 7));
            wb_we0 = ($urandom_range(0, 9) < 3); wb_we1 = ($urandom_range(0, 9) < 3);
            wb_rd0 = 5'($urandom_range(0, 7)); wb_rd1 = 5'($urandom_range(0, 7));
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
